mips_cpu_writeback_arbiter: RTL and testbench
=============================================

Name: mips_cpu_writeback_arbiter

Overview:
Write-side driver of the register file. Merges register-write requests from the single-cycle ALU path and the load-response path into the single write port (WENREG/Rd/RdDATA). Buffers ALU results that lose arbitration in a small FIFO. Keeps a pending-load scoreboard that the issue stage uses to stall on load-use hazards.

Parameters:
FIFO_DEPTH, 2, number of buffered ALU write requests (power of 2, ≥2)

Ports:
clk  input  1  system clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
alu_valid  input  1  ALU write request present
alu_ready  output  1  ALU request accepted this cycle when alu_valid && alu_ready
alu_rd  input  5  ALU destination register
alu_data  input  32  ALU result
ld_valid  input  1  load response present; never back-pressured
ld_rd  input  5  load destination register
ld_data  input  32  load data
reserve_valid  input  1  issue stage has issued a load to reserve_rd
reserve_rd  input  5  register reserved by the issued load
query_rs  input  5  issue-stage source register A
query_rt  input  5  issue-stage source register B
rs_pending  output  1  query_rs has an outstanding write
rt_pending  output  1  query_rt has an outstanding write
WENREG  output  1  register-file write enable
Rd  output  5  register-file write address
RdDATA  output  32  register-file write data

Behaviour:
- Reset (synchronous, when RESET=1 at the clock edge):
  - WENREG=0, Rd=0, RdDATA=0.
  - FIFO emptied; scoreboard cleared.
  - Any in-flight request is dropped, including during a reset asserted mid-stream.
  - alu_ready=1 in the cycle after reset.
- Output stage: WENREG/Rd/RdDATA are registered. A request selected in cycle N appears on the outputs in cycle N+1 and the register file writes it at the end of N+1. Exactly one write is selected per cycle.
- Selection priority each cycle:
  1. ld_valid
  2. FIFO head
  3. the accepted ALU request, which bypasses the FIFO only when the FIFO is empty
  - Unselected accepted ALU requests are enqueued.
  - If no source is selected, WENREG=0 next cycle; Rd and RdDATA hold their previous values.
- alu_ready = (FIFO count < FIFO_DEPTH). This is combinational from registered count only and does not depend on ld_valid.
- Simultaneous dequeue and enqueue in the same cycle leaves count unchanged. The full FIFO plus a dequeue in the same cycle still reports alu_ready=0 that cycle, because the check uses the registered count.
- FIFO order is strictly in order; pointers wrap modulo FIFO_DEPTH.
- Register $zero: a selected request with rd=0 is consumed normally, but WENREG stays 0 for it.
- Scoreboard: 32-bit pending vector; bit 0 is always 0.
  - reserve_valid with reserve_rd≠0 sets the bit.
  - A selected load with ld_rd=r clears bit r.
  - Set and clear of the same bit in the same cycle: set wins, since a newer load was issued.
- Hazard outputs (combinational):
  - rs_pending = pending[query_rs] OR any valid FIFO entry with rd==query_rs≠0.
  - rt_pending is the same function applied to query_rt.
- ALU requests are never reordered relative to each other. Loads may overtake buffered ALU writes; the issue stage must not have an ALU write and a load outstanding to the same rd.

Test Plan:
1. Reset, then alu_valid=1, alu_rd=2, alu_data=49 for one cycle, no load -> the next cycle shows WENREG=1, Rd=2, RdDATA=49; the following cycle shows WENREG=0.
2. ALU (rd=3, data=38025) and load (rd=5, data=0x1234) in the same cycle, FIFO empty -> the cycle after shows Rd=5/0x1234, then Rd=3/38025; with query_rs=3 the same cycle, rs_pending=1 while the entry is buffered.
3. ld_valid held for 4 cycles while ALU issues rd=8,9,10 -> alu_ready falls to 0 after 2 accepts and rd=10 is held off. After the loads end, the writes appear as 8, 9, 10 in consecutive cycles, and alu_ready returns to 1.
4. reserve_valid with rd=7, query_rt=7 -> rt_pending=1 from the next cycle. Load response rd=7 -> rt_pending=0 the cycle after selection. A same-cycle reserve of 7 plus load of 7 -> the bit stays 1.
5. ALU rd=0, data=0xFFFFFFFF; reserve_rd=0 -> WENREG never asserts; a query of 0 gives pending 0.
6. Fill the FIFO (2 entries) and reserve rd=4, then assert RESET for 1 cycle -> WENREG=0, Rd=0, RdDATA=0, alu_ready=1, and all pending outputs are 0; no buffered write appears afterwards.

Source files
------------

// File: rtl/mips_cpu_writeback_arbiter_if.sv
// Bundle of ALU/load write requests, scoreboard queries and register-file write port
// between the issue/execute side (master) and the writeback arbiter (slave).
interface mips_cpu_writeback_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        reserve_valid;
  logic [4:0]  reserve_rd;
  logic [4:0]  query_rs;
  logic [4:0]  query_rt;
  logic        rs_pending;
  logic        rt_pending;
  logic        WENREG;
  logic [4:0]  Rd;
  logic [31:0] RdDATA;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           reserve_valid, reserve_rd, query_rs, query_rt,
    input  alu_ready, rs_pending, rt_pending, WENREG, Rd, RdDATA
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           reserve_valid, reserve_rd, query_rs, query_rt,
    output alu_ready, rs_pending, rt_pending, WENREG, Rd, RdDATA
  );
endinterface

// File: rtl/mips_cpu_writeback_arbiter.sv
// Register-file write arbiter: loads beat buffered ALU writes, which beat a fresh ALU
// write; losing ALU writes queue in order. Also tracks pending loads for hazard stalls.
module mips_cpu_writeback_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input logic                         clk,
  input logic                         RESET,
  mips_cpu_writeback_arbiter_if.slave wb
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [4:0]       fifo_rd_q   [FIFO_DEPTH];
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pending_q, pending_d;
  logic             wen_q, wen_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      data_q, data_d;

  logic                  alu_acc, fifo_empty, sel_ld, sel_fifo, sel_alu, enq, deq;
  logic [FIFO_DEPTH-1:0] slot_valid;

  assign wb.alu_ready = (count_q < DEPTH_C);
  assign alu_acc      = wb.alu_valid && wb.alu_ready;
  assign fifo_empty   = (count_q == '0);
  assign sel_ld       = wb.ld_valid;
  assign sel_fifo     = !wb.ld_valid && !fifo_empty;
  assign sel_alu      = !wb.ld_valid && fifo_empty && alu_acc;
  assign enq          = alu_acc && !sel_alu;
  assign deq          = sel_fifo;

  // A slot is live when its distance from head (mod depth) is below the count.
  always_comb begin
    logic [PTR_W-1:0] off;
    slot_valid = '0;
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      off           = PTR_W'(j) - head_q;
      slot_valid[j] = ({1'b0, off} < count_q);
    end
  end

  function automatic logic hazard(input logic [4:0] q);
    logic h;
    h = pending_q[q];
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      if (slot_valid[j] && (fifo_rd_q[j] == q) && (q != 5'd0)) h = 1'b1;
    end
    return h;
  endfunction

  assign wb.rs_pending = hazard(wb.query_rs);
  assign wb.rt_pending = hazard(wb.query_rt);

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    wen_d     = 1'b0;
    rd_d      = rd_q;
    data_d    = data_q;
    pending_d = pending_q;
    if (deq) head_d = head_q + PTR_W'(1);
    if (enq) tail_d = tail_q + PTR_W'(1);
    if (enq && !deq)      count_d = count_q + CNT_W'(1);
    else if (deq && !enq) count_d = count_q - CNT_W'(1);
    if (sel_ld) begin
      rd_d   = wb.ld_rd;
      data_d = wb.ld_data;
    end else if (sel_fifo) begin
      rd_d   = fifo_rd_q[head_q];
      data_d = fifo_data_q[head_q];
    end else if (sel_alu) begin
      rd_d   = wb.alu_rd;
      data_d = wb.alu_data;
    end
    // Writes to $zero are consumed but never enable the register file.
    wen_d = (sel_ld || sel_fifo || sel_alu) && (rd_d != 5'd0);
    // Clear before set so a newly issued load to the same register keeps its reservation.
    if (sel_ld) pending_d[wb.ld_rd] = 1'b0;
    if (wb.reserve_valid && (wb.reserve_rd != 5'd0)) pending_d[wb.reserve_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      wen_q     <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      wen_q     <= wen_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd_q[tail_q]   <= wb.alu_rd;
      fifo_data_q[tail_q] <= wb.alu_data;
    end
  end

  assign wb.WENREG = wen_q;
  assign wb.Rd     = rd_q;
  assign wb.RdDATA = data_q;
endmodule

// File: tb/tb_mips_cpu_writeback_arbiter.sv
// Bench for the writeback arbiter: directed scenarios then random traffic, all checked
// against a queue-based reference model of the arbitration and scoreboard rules.
module tb_mips_cpu_writeback_arbiter;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_cpu_writeback_arbiter_if wb ();

  mips_cpu_writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .RESET (rst),
    .wb    (wb)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } req_t;

  req_t        mq[$];
  bit   [31:0] mpend;
  bit          m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hz(input logic [4:0] q);
    bit h;
    h = mpend[q];
    foreach (mq[i]) if (mq[i].rd == q && q != 5'd0) h = 1'b1;
    return h;
  endfunction

  task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ldd,
                       input bit rv, input logic [4:0] rrd,
                       input logic [4:0] qs, input logic [4:0] qt);
    wb.alu_valid     = av;
    wb.alu_rd        = ard;
    wb.alu_data      = ad;
    wb.ld_valid      = lv;
    wb.ld_rd         = lrd;
    wb.ld_data       = ldd;
    wb.reserve_valid = rv;
    wb.reserve_rd    = rrd;
    wb.query_rs      = qs;
    wb.query_rt      = qt;
  endtask

  task automatic idle(input logic [4:0] qs, input logic [4:0] qt);
    drive(0, 0, 0, 0, 0, 0, 0, 0, qs, qt);
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    bit   rdy, acc, sel, lv, rv, r;
    req_t a, l, s;
    logic [4:0] rrd;
    #2;
    rdy = (mq.size() < DEPTH);
    chk("alu_ready", wb.alu_ready, rdy);
    chk("rs_pending", wb.rs_pending, hz(wb.query_rs));
    chk("rt_pending", wb.rt_pending, hz(wb.query_rt));
    acc = wb.alu_valid && rdy;
    a   = '{wb.alu_rd, wb.alu_data};
    l   = '{wb.ld_rd, wb.ld_data};
    lv  = wb.ld_valid;
    rv  = wb.reserve_valid;
    rrd = wb.reserve_rd;
    r   = rst;
    @(posedge clk);
    if (r) begin
      mq.delete();
      mpend  = '0;
      m_wen  = 1'b0;
      m_rd   = '0;
      m_data = '0;
    end else begin
      sel = 1'b1;
      s   = '{5'd0, 32'd0};
      if (lv) begin
        s = l;
        if (acc) mq.push_back(a);
      end else if (mq.size() != 0) begin
        s = mq.pop_front();
        if (acc) mq.push_back(a);
      end else if (acc) begin
        s = a;
      end else begin
        sel = 1'b0;
      end
      m_wen = sel && (s.rd != 5'd0);
      if (sel) begin
        m_rd   = s.rd;
        m_data = s.data;
      end
      if (lv) mpend[l.rd] = 1'b0;
      if (rv && rrd != 5'd0) mpend[rrd] = 1'b1;
    end
    #1;
    chk("WENREG", wb.WENREG, m_wen);
    if (m_wen || r) begin
      chk("Rd", wb.Rd, m_rd);
      chk("RdDATA", wb.RdDATA, m_data);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle(0, 0);
    repeat (2) @(posedge clk);
    #1;
    mq.delete();
    mpend = '0; m_wen = 0; m_rd = 0; m_data = 0;
    chk("rst_wen", wb.WENREG, 0);
    chk("rst_rd", wb.Rd, 0);
    chk("rst_data", wb.RdDATA, 0);
    chk("rst_ready", wb.alu_ready, 1);
    rst = 1'b0;

    // Single ALU write passes straight through.
    drive(1, 2, 49, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("t1_wen", wb.WENREG, 1);
    chk("t1_rd", wb.Rd, 2);
    chk("t1_data", wb.RdDATA, 49);
    idle(0, 0);
    step();
    chk("t1_wen_off", wb.WENREG, 0);

    // Load wins, ALU write buffered and visible to hazard query.
    drive(1, 3, 38025, 1, 5, 32'h1234, 0, 0, 3, 0);
    step();
    chk("t2_rd_ld", wb.Rd, 5);
    chk("t2_data_ld", wb.RdDATA, 32'h1234);
    idle(3, 0);
    #2;
    chk("t2_rs_pending", wb.rs_pending, 1);
    step();
    chk("t2_rd_alu", wb.Rd, 3);
    chk("t2_data_alu", wb.RdDATA, 38025);

    // Loads hold the port while the FIFO fills; rd=10 is stalled until space frees.
    drive(1, 8, 800, 1, 20, 32'hA0, 0, 0, 8, 9);  step();
    drive(1, 9, 900, 1, 21, 32'hA1, 0, 0, 8, 9);  step();
    drive(1, 10, 1000, 1, 22, 32'hA2, 0, 0, 10, 9); step();
    chk("t3_ready_full", wb.alu_ready, 0);
    drive(1, 10, 1000, 1, 23, 32'hA3, 0, 0, 10, 8); step();
    drive(1, 10, 1000, 0, 0, 0, 0, 0, 10, 9); step();
    chk("t3_first", wb.Rd, 8);
    drive(1, 10, 1000, 0, 0, 0, 0, 0, 10, 9); step();
    chk("t3_second", wb.Rd, 9);
    idle(10, 0); step();
    chk("t3_third", wb.Rd, 10);
    idle(0, 0); step();
    chk("t3_ready_back", wb.alu_ready, 1);

    // Scoreboard set, clear, and same-cycle set-beats-clear.
    drive(0, 0, 0, 0, 0, 0, 1, 7, 0, 7); step();
    idle(0, 7); step();
    drive(0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 7); step();
    idle(0, 7); step();
    drive(0, 0, 0, 0, 0, 0, 1, 7, 0, 7); step();
    drive(0, 0, 0, 1, 7, 32'h78, 1, 7, 0, 7); step();
    idle(0, 7); #2;
    chk("t4_set_wins", wb.rt_pending, 1);
    step();
    drive(0, 0, 0, 1, 7, 32'h79, 0, 0, 0, 7); step();

    // Register zero is never written nor reserved.
    drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0); step();
    chk("t5_wen_zero", wb.WENREG, 0);
    idle(0, 0); step();

    // Mid-stream reset drops buffered writes and reservations.
    drive(1, 11, 1100, 1, 24, 32'hB0, 1, 4, 11, 4); step();
    drive(1, 12, 1200, 1, 25, 32'hB1, 0, 0, 12, 4); step();
    rst = 1'b1;
    idle(11, 4); step();
    rst = 1'b0;
    chk("t6_rd", wb.Rd, 0);
    chk("t6_data", wb.RdDATA, 0);
    chk("t6_ready", wb.alu_ready, 1);
    #1;
    chk("t6_rs", wb.rs_pending, 0);
    chk("t6_rt", wb.rt_pending, 0);
    repeat (4) begin idle(11, 4); step(); end

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
